// File: rtl/matriz_pkg.sv
// Shared constants, opcodes and element helpers for the 5x5 matrix ALU.
// Elements are packed row-major: element k = r*ORDEM+c at bits [LARGURA*k +: LARGURA].
package matriz_pkg;

    localparam int ORDEM    = 5;
    localparam int LARGURA  = 9;
    localparam int NUM_ELEM = ORDEM * ORDEM;
    localparam int ACC_LARG = 21;
    localparam int MAT_LARG = NUM_ELEM * LARGURA;
    localparam int IDX_LARG = 5;
    localparam int CNT_LARG = 3;

    localparam logic [2:0] OP_SOMA     = 3'b000;
    localparam logic [2:0] OP_SUB      = 3'b001;
    localparam logic [2:0] OP_MULT     = 3'b010;
    localparam logic [2:0] OP_ESCALAR  = 3'b011;
    localparam logic [2:0] OP_TRANSP   = 3'b100;
    localparam logic [2:0] OP_OPOSTA   = 3'b101;

    localparam logic signed [ACC_LARG-1:0] SAT_MAX = 21'sd255;
    localparam logic signed [ACC_LARG-1:0] SAT_MIN = -21'sd256;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        EXEC   = 2'd1,
        FIM    = 2'd2
    } estado_t;

    function automatic logic [IDX_LARG-1:0] pos(input logic [CNT_LARG-1:0] lin,
                                                input logic [CNT_LARG-1:0] col);
        return IDX_LARG'(int'(lin) * ORDEM + int'(col));
    endfunction

    function automatic logic signed [LARGURA-1:0] elem(input logic [MAT_LARG-1:0] m,
                                                       input logic [IDX_LARG-1:0] idx);
        return m[int'(idx)*LARGURA +: LARGURA];
    endfunction

endpackage

// File: rtl/mac_saturado.sv
// 21-bit accumulator whose combinational output is sat(acc + termo) to 9 bits.
// With clr held the unit degenerates to a plain saturator for element-wise ops.
module mac_saturado
    import matriz_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       acc_en_i,
    input  logic signed [ACC_LARG-1:0] termo_i,
    output logic signed [LARGURA-1:0]  valor_o,
    output logic                       sat_o
);

    logic signed [ACC_LARG-1:0] acc_q;
    logic signed [ACC_LARG-1:0] acc_d;
    logic signed [ACC_LARG-1:0] soma;

    always_comb begin
        soma  = acc_q + termo_i;
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (acc_en_i)
            acc_d = soma;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    always_comb begin
        sat_o   = 1'b0;
        valor_o = soma[LARGURA-1:0];
        if (soma > SAT_MAX) begin
            sat_o   = 1'b1;
            valor_o = SAT_MAX[LARGURA-1:0];
        end else if (soma < SAT_MIN) begin
            sat_o   = 1'b1;
            valor_o = SAT_MIN[LARGURA-1:0];
        end
    end

endmodule

// File: rtl/ula_matriz.sv
// Sequential 5x5 matrix ALU: one element (or one MAC step) per cycle, start/pronto handshake.
// Results and the sticky overflow are published together in FIM.
module ula_matriz #(
    parameter int ORDEM   = 5,
    parameter int LARGURA = 9
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [2:0]                       opcode,
    input  logic [LARGURA-1:0]               escalar,
    input  logic [ORDEM*ORDEM*LARGURA-1:0]   matriz1,
    input  logic [ORDEM*ORDEM*LARGURA-1:0]   matriz2,
    output logic [ORDEM*ORDEM*LARGURA-1:0]   matriz_resultante,
    output logic                             pronto,
    output logic                             ocupado,
    output logic                             overflow
);
    import matriz_pkg::*;

    estado_t                    estado_q;
    logic [MAT_LARG-1:0]        a_q, b_q, res_q, saida_q;
    logic [2:0]                 op_q;
    logic signed [LARGURA-1:0]  esc_q;
    logic [IDX_LARG-1:0]        k_q;
    logic [CNT_LARG-1:0]        lin_q, col_q, j_q;
    logic [CNT_LARG-1:0]        lin_d, col_d;
    logic                       ovf_q, pronto_q, ocupado_q, overflow_q;

    logic signed [LARGURA-1:0]  a_el, b_el, a_tr, mul_a, mul_b;
    logic signed [17:0]         prod;
    logic signed [9:0]          soma10, dif10, neg10;
    logic signed [ACC_LARG-1:0] termo;
    logic signed [LARGURA-1:0]  mac_valor;
    logic                       mac_sat, mac_en, mac_clr, ultimo_j, ultimo_k;

    // One shared multiplier: MAC operands for the product, A[k]*escalar otherwise.
    always_comb begin
        a_el   = elem(a_q, pos(lin_q, col_q));
        b_el   = elem(b_q, pos(lin_q, col_q));
        a_tr   = elem(a_q, pos(col_q, lin_q));
        mul_a  = (op_q == OP_MULT) ? elem(a_q, pos(lin_q, j_q)) : a_el;
        mul_b  = (op_q == OP_MULT) ? elem(b_q, pos(j_q, col_q)) : esc_q;
        prod   = mul_a * mul_b;
        soma10 = {a_el[LARGURA-1], a_el} + {b_el[LARGURA-1], b_el};
        dif10  = {a_el[LARGURA-1], a_el} - {b_el[LARGURA-1], b_el};
        neg10  = 10'sd0 - {a_el[LARGURA-1], a_el};
        case (op_q)
            OP_SOMA:    termo = ACC_LARG'(soma10);
            OP_SUB:     termo = ACC_LARG'(dif10);
            OP_MULT:    termo = ACC_LARG'(prod);
            OP_ESCALAR: termo = ACC_LARG'(prod);
            OP_TRANSP:  termo = ACC_LARG'(a_tr);
            OP_OPOSTA:  termo = ACC_LARG'(neg10);
            default:    termo = '0;
        endcase
    end

    always_comb begin
        mac_en   = (estado_q == EXEC) && (op_q == OP_MULT);
        ultimo_j = (op_q != OP_MULT) || (j_q == CNT_LARG'(ORDEM - 1));
        ultimo_k = (k_q == IDX_LARG'(NUM_ELEM - 1));
        mac_clr  = !mac_en || ultimo_j;
        if (col_q == CNT_LARG'(ORDEM - 1)) begin
            col_d = '0;
            lin_d = lin_q + 1'b1;
        end else begin
            col_d = col_q + 1'b1;
            lin_d = lin_q;
        end
    end

    mac_saturado u_mac (
        .clk_i    (clk),
        .rst_i    (reset),
        .clr_i    (mac_clr),
        .acc_en_i (mac_en),
        .termo_i  (termo),
        .valor_o  (mac_valor),
        .sat_o    (mac_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            saida_q    <= '0;
            op_q       <= '0;
            esc_q      <= '0;
            k_q        <= '0;
            lin_q      <= '0;
            col_q      <= '0;
            j_q        <= '0;
            ovf_q      <= 1'b0;
            pronto_q   <= 1'b0;
            ocupado_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (start) begin
                        a_q        <= matriz1;
                        b_q        <= matriz2;
                        op_q       <= opcode;
                        esc_q      <= escalar;
                        k_q        <= '0;
                        lin_q      <= '0;
                        col_q      <= '0;
                        j_q        <= '0;
                        ovf_q      <= 1'b0;
                        overflow_q <= 1'b0;
                        ocupado_q  <= 1'b1;
                        estado_q   <= EXEC;
                    end
                end
                EXEC: begin
                    if (!ultimo_j) begin
                        j_q <= j_q + 1'b1;
                    end else begin
                        res_q[int'(k_q)*LARGURA +: LARGURA] <= mac_valor;
                        ovf_q <= ovf_q | mac_sat;
                        j_q   <= '0;
                        k_q   <= k_q + 1'b1;
                        lin_q <= lin_d;
                        col_q <= col_d;
                        if (ultimo_k)
                            estado_q <= FIM;
                    end
                end
                FIM: begin
                    saida_q    <= res_q;
                    overflow_q <= ovf_q;
                    pronto_q   <= 1'b1;
                    ocupado_q  <= 1'b0;
                    estado_q   <= OCIOSO;
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

    assign matriz_resultante = saida_q;
    assign pronto            = pronto_q;
    assign ocupado           = ocupado_q;
    assign overflow          = overflow_q;

endmodule
